core_mem_responder: RTL
=======================

# core_mem_responder

Memory-side responder for the core's instruction and data buses. It holds a unified word-addressed RAM that serves combinational instruction fetch from `pc` and registered data reads from the core's ALU address. It performs byte-lane writes driven by the core's 4-bit write strobes. A small MMIO window provides a 64-bit cycle timer, a timer-compare interrupt and a `tohost` halt register, so test programs can time themselves and signal completion.

## Interface
Parameters:
- `MEM_WORDS`, 4096: RAM depth in 32-bit words; power of two.
- `MMIO_BASE`, 32'hFFFF_0000: base address of the 32-byte MMIO window; low 5 bits zero.
- `INIT_FILE`, "": hex image loaded into RAM at elaboration; empty means no preload.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pc`  in  32  instruction fetch address.
- `instruction`  out  32  fetched word, combinational from `pc`.
- `addr`  in  32  data address, driven by the core's ALU output.
- `wdata`  in  32  store data, already lane-aligned by the core.
- `we`  in  4  byte write strobes; bit i writes `wdata[8i+7:8i]`.
- `rdata`  out  32  registered read data for the previous cycle's `addr`.
- `timer_irq`  out  1  high while mtime ≥ mtimecmp (unsigned 64-bit).
- `halt`  out  1  sticky; set by a nonzero write to TOHOST.
- `tohost`  out  32  last value written to TOHOST.
- `bus_err`  out  1  one-cycle pulse on a write to an unmapped address.

## Operation
- **Address decode** (on `addr[31:2]`; `addr[1:0]` ignored):
  - RAM when `addr < MEM_WORDS*4`; word index is `addr[log2(MEM_WORDS)+1:2]`.
  - MMIO when `addr[31:5] == MMIO_BASE[31:5]`.
  - Anything else is unmapped.
- **Fetch**:
  - `instruction` = RAM word at `pc[...:2]` when `pc` is in RAM range.
  - Otherwise `instruction` = 32'h0000_0013 (NOP).
- **Data read**: every cycle, `rdata` registers the read value of the current `addr`; there is no read enable.
  - Unmapped reads return 0 and raise no error.
- **RAM write**: lanes with `we[i]=1` are updated at the clock edge; other lanes are unchanged.
- **MMIO registers** (byte offset from `MMIO_BASE`):
  - 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 TOHOST.
  - Offsets 0x14–0x1C read 0; writes to them are ignored.
- **MMIO writes**: any `we != 0` writes the full 32-bit word; partial strobes are treated as full-word writes.
- **mtime counter**:
  - Increments by 1 every cycle while `halt=0`; wraps 2^64−1 → 0.
  - A write to MTIME_LO or MTIME_HI replaces that half and suppresses the increment for that cycle.
- **HI/LO read coherence**:
  - A read of MTIME_LO returns the low word and latches the high word into `mtime_hi_shadow`.
  - A read of MTIME_HI returns the shadow, so a LO-then-HI read pair is coherent.
- **tohost**:
  - Any write updates `tohost`.
  - A nonzero value also sets `halt`, which stays set until `rst`.
  - After `halt`, RAM and MMIO still accept accesses; only mtime freezes.
- **Unmapped writes**: dropped; `bus_err`=1 for the following cycle.

## Timing
- `instruction` has zero-cycle latency from `pc`.
- `rdata` has one-cycle latency: the value for `addr` at edge N is valid after edge N+1. This matches the core's delayed-load sign extension.
- **Read during write**, same address, same cycle: read-before-write; `rdata` shows the old word.
- **Fetch during write**, same word, same cycle: `instruction` shows the old word until the edge.
- `timer_irq` is registered: it reflects the compare of the post-edge mtime/mtimecmp values one cycle after they change.
- **Reset values**: `rdata`=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, shadow=0, `tohost`=0, `halt`=0, `timer_irq`=0, `bus_err`=0.
  - RAM contents are not reset; they keep the `INIT_FILE` image or prior writes.
- **Reset asserted mid-operation**:
  - All registers above take their reset values at that edge.
  - A write presented in the same cycle as `rst` is still committed to RAM.
  - MMIO writes in that cycle are discarded.

## Structure
- Shared package `core_mem_pkg`:
  - MMIO offset constants (`MTIME_LO_OFF`…`TOHOST_OFF`).
  - `NOP_INSN` = 32'h0000_0013.
  - Region-decode enum {REG_RAM, REG_MMIO, REG_UNMAPPED}.
- Sub-module `mmio_timer`: mtime, mtimecmp, shadow and irq logic.
- The top level holds the RAM array, decode, tohost/halt, bus_err and the `rdata` mux.

## Test plan
- **Byte-lane write**: write 32'h1122_3344 with `we`=4'hF to 0x40, then `we`=4'b0010 with `wdata`=32'h0000_AA00 → read of 0x40 gives `rdata`=32'h1122_AA44 one cycle after the address is presented.
- **Read-before-write**: same-cycle write of 32'hDEAD_BEEF and read at 0x80 (old value 0) → `rdata`=0; the next-cycle read of 0x80 gives 32'hDEAD_BEEF.
- **Fetch**: `pc`=0x0 fetches the preloaded word; `pc`=MEM_WORDS*4 → `instruction`=32'h0000_0013.
- **Timer**:
  - After reset, MTIME_LO reads 5 when sampled at cycle 5.
  - Write MTIMECMP_HI=0 and MTIMECMP_LO=20 → `timer_irq` rises when mtime reaches 20, observed one cycle later.
  - Write MTIME_LO=32'hFFFF_FFFF → HI increments on the next tick.
- **Halt**: write TOHOST=0 → `halt` stays 0; write TOHOST=1 → `halt`=1, `tohost`=1, mtime frozen; `rst` → all cleared.
- **Unmapped**: write with `we`=4'h1 to 32'h8000_0000 → `bus_err` pulses exactly one cycle and RAM is unchanged; a read there → `rdata`=0 and no `bus_err`.

Source files
------------

// File: rtl/core_mem_pkg.sv
// Shared constants and types for the core memory responder.
package core_mem_pkg;

   // Byte offsets of the MMIO registers inside the 32-byte window.
   localparam logic [4:0] MTIME_LO_OFF    = 5'h00;
   localparam logic [4:0] MTIME_HI_OFF    = 5'h04;
   localparam logic [4:0] MTIMECMP_LO_OFF = 5'h08;
   localparam logic [4:0] MTIMECMP_HI_OFF = 5'h0C;
   localparam logic [4:0] TOHOST_OFF      = 5'h10;

   // Returned on fetches outside the RAM (addi x0, x0, 0).
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_MMIO,
      REG_UNMAPPED
   } region_e;

   // Word slot of an MMIO byte offset.
   function automatic logic [2:0] mmio_slot(input logic [4:0] off);
      return off[4:2];
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// 64-bit cycle timer with compare interrupt and coherent HI/LO reads.
module mmio_timer
   import core_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        halt,
   input  logic        wr_en,
   input  logic [2:0]  wr_slot,
   input  logic [31:0] wdata,
   input  logic        rd_en,
   input  logic [2:0]  rd_slot,
   output logic [31:0] rd_data,
   output logic        timer_irq
);

   localparam logic [2:0] S_MTIME_LO    = mmio_slot(MTIME_LO_OFF);
   localparam logic [2:0] S_MTIME_HI    = mmio_slot(MTIME_HI_OFF);
   localparam logic [2:0] S_MTIMECMP_LO = mmio_slot(MTIMECMP_LO_OFF);
   localparam logic [2:0] S_MTIMECMP_HI = mmio_slot(MTIMECMP_HI_OFF);

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic [31:0] shadow_q, shadow_d;
   logic        irq_q, irq_d;

   // Next-state for counter, compare, shadow and interrupt; read mux.
   always_comb begin
      mtime_d    = mtime_q;
      mtimecmp_d = mtimecmp_q;
      shadow_d   = shadow_q;
      // Registered compare of the current (post-edge) values.
      irq_d      = (mtime_q >= mtimecmp_q);
      rd_data    = '0;

      // A software write to either half replaces the tick for that cycle.
      if (wr_en && (wr_slot == S_MTIME_LO)) begin
         mtime_d[31:0] = wdata;
      end else if (wr_en && (wr_slot == S_MTIME_HI)) begin
         mtime_d[63:32] = wdata;
      end else if (!halt) begin
         mtime_d = mtime_q + 64'd1;
      end

      if (wr_en && (wr_slot == S_MTIMECMP_LO)) begin
         mtimecmp_d[31:0] = wdata;
      end
      if (wr_en && (wr_slot == S_MTIMECMP_HI)) begin
         mtimecmp_d[63:32] = wdata;
      end

      // Reading LO snapshots HI so a following HI read is coherent.
      if (rd_en && (rd_slot == S_MTIME_LO)) begin
         shadow_d = mtime_q[63:32];
      end

      case (rd_slot)
         S_MTIME_LO:    rd_data = mtime_q[31:0];
         S_MTIME_HI:    rd_data = shadow_q;
         S_MTIMECMP_LO: rd_data = mtimecmp_q[31:0];
         S_MTIMECMP_HI: rd_data = mtimecmp_q[63:32];
         default:       rd_data = '0;
      endcase
   end

   // Timer state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         shadow_q   <= '0;
         irq_q      <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         shadow_q   <= shadow_d;
         irq_q      <= irq_d;
      end
   end

   // Interrupt output.
   always_comb timer_irq = irq_q;

endmodule

// File: rtl/core_mem_responder.sv
// Unified instruction/data RAM with byte-lane writes and an MMIO window
// holding the cycle timer and the tohost halt register.
module core_mem_responder
  import core_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  output logic [31:0] rdata,
  output logic        timer_irq,
  output logic        halt,
  output logic [31:0] tohost,
  output logic        bus_err
);

  localparam int unsigned AW       = $clog2(MEM_WORDS);
  localparam logic [2:0]  S_TOHOST = mmio_slot(TOHOST_OFF);

  logic [31:0]   mem [MEM_WORDS];

  region_e       d_region;
  region_e       f_region;
  logic [AW-1:0] d_idx;
  logic [AW-1:0] f_idx;
  logic [2:0]    d_slot;
  logic [3:0]    ram_we;
  logic          mmio_wr;
  logic          mmio_rd;
  logic [31:0]   timer_rd;
  logic          unused_lsbs;

  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   tohost_q, tohost_d;
  logic          halt_q, halt_d;
  logic          bus_err_q, bus_err_d;

  function automatic region_e decode(input logic [31:0] a);
    region_e r;
    if (a[31:AW+2] == '0) begin
      r = REG_RAM;
    end else if (a[31:5] == MMIO_BASE[31:5]) begin
      r = REG_MMIO;
    end else begin
      r = REG_UNMAPPED;
    end
    return r;
  endfunction

  // Address decode for the data and fetch ports.
  always_comb begin
    d_region    = decode(addr);
    f_region    = decode(pc);
    d_idx       = addr[AW+1:2];
    f_idx       = pc[AW+1:2];
    d_slot      = addr[4:2];
    ram_we      = (d_region == REG_RAM) ? we : 4'h0;
    mmio_wr     = (d_region == REG_MMIO) && (we != 4'h0);
    mmio_rd     = (d_region == REG_MMIO);
    unused_lsbs = ^{pc[1:0], addr[1:0]};
  end

  // Byte-lane RAM writes; not gated by reset so in-flight stores land.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (ram_we[i]) begin
        mem[d_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Combinational fetch; pre-edge contents are visible during a write.
  always_comb begin
    instruction = NOP_INSN;
    if (f_region == REG_RAM) begin
      instruction = mem[f_idx];
    end
  end

  mmio_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .halt      (halt_q),
    .wr_en     (mmio_wr),
    .wr_slot   (d_slot),
    .wdata     (wdata),
    .rd_en     (mmio_rd),
    .rd_slot   (d_slot),
    .rd_data   (timer_rd),
    .timer_irq (timer_irq)
  );

  // Read mux, tohost/halt and bus error next-state.
  always_comb begin
    rdata_d   = '0;
    tohost_d  = tohost_q;
    halt_d    = halt_q;
    bus_err_d = (d_region == REG_UNMAPPED) && (we != 4'h0);

    case (d_region)
      REG_RAM:  rdata_d = mem[d_idx];
      REG_MMIO: begin
        if (d_slot < S_TOHOST) begin
          rdata_d = timer_rd;
        end else if (d_slot == S_TOHOST) begin
          rdata_d = tohost_q;
        end
      end
      default:  rdata_d = '0;
    endcase

    if (mmio_wr && (d_slot == S_TOHOST)) begin
      tohost_d = wdata;
      if (wdata != '0) begin
        halt_d = 1'b1;
      end
    end
  end

  // Top-level registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      tohost_q  <= '0;
      halt_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      tohost_q  <= tohost_d;
      halt_q    <= halt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Output drives.
  always_comb begin
    rdata   = rdata_q;
    tohost  = tohost_q;
    halt    = halt_q;
    bus_err = bus_err_q;
  end

endmodule
